any1_rob_ctrl: RTL and testbench
================================

ANY1_ROB_CTRL -- requirements
Module: any1_rob_ctrl

Interface
REQ-001 SHALL have parameter ROB_ENTRIES, default 64 (package value), number of reorder entries; power of two, 4..64.
REQ-002 SHALL have port rst_i  in  1  asynchronous active-high reset.
REQ-003 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port alloc_req_i  in  1  decode requests one new entry.
REQ-005 SHALL have port alloc_gnt_o  out  1  allocation granted this cycle.
REQ-006 SHALL have port alloc_rid_o  out  6  rid assigned (current tail index).
REQ-007 SHALL have port done_i  in  1  execution unit reports result ready.
REQ-008 SHALL have port done_rid_i  in  6  rid of completed entry.
REQ-009 SHALL have port cmt_o  out  1  head entry offered for commit.
REQ-010 SHALL have port cmt_rid_o  out  6  rid of head entry.
REQ-011 SHALL have port cmt_rdy_i  in  1  register file accepts commit.
REQ-012 SHALL have port flush_i  in  1  redirect: squash entries younger than flush_rid_i.
REQ-013 SHALL have port flush_rid_i  in  6  youngest surviving rid (the redirecting branch).
REQ-014 SHALL have ports count_o out 7 occupancy; full_o out 1; empty_o out 1.

Function
REQ-015 SHALL keep head and tail pointers, each index plus one wrap bit; count = tail - head modulo 2*ROB_ENTRIES; full when indices equal and wrap bits differ; empty when pointers equal.
REQ-016 SHALL keep per-entry v (allocated) and d (done) bits.
REQ-017 SHALL run FSM states RUN and FLUSH; reset enters RUN; flush_i in RUN -> FLUSH; FLUSH -> RUN unconditionally next cycle.
REQ-018 SHALL drive alloc_gnt_o = alloc_req_i & ~full_o & ~flush_i & state==RUN, combinationally; alloc_rid_o = tail index at all times.
REQ-019 SHALL on grant set v[tail], clear d[tail], increment tail with wrap at ROB_ENTRIES toggling wrap bit.
REQ-020 SHALL on done_i set d[done_rid_i] only if v[done_rid_i]; done to invalid entry ignored.
REQ-021 SHALL drive cmt_o = v[head] & d[head] & state==RUN; cmt_rid_o = head index always.
REQ-022 SHALL on cmt_o & cmt_rdy_i clear v[head] and increment head; at most one commit per cycle.
REQ-023 SHALL on flush_i in RUN, if v[flush_rid_i], clear v for all entries from flush_rid_i+1 up to tail-1 and set tail to flush_rid_i+1 with correct wrap bit; flush to invalid rid squashes nothing.
REQ-024 SHALL, when flush_i and commit coincide, perform the head commit and the truncation in the same cycle; head entry never squashed.
REQ-025 SHALL give flush priority over allocation; done_i in same cycle as flush applies only if target survives.
REQ-026 SHALL ignore flush_i while in FLUSH state.
REQ-027 SHALL refuse allocation when full even if a commit occurs the same cycle (no bypass).
REQ-028 SHALL see done_i on head take effect in d the next cycle; cmt_o rises one cycle after done_i at earliest.
REQ-029 SHALL drive count_o, full_o, empty_o from registered pointers only.

Reset
REQ-030 SHALL on rst_i asynchronously set head=tail=0, all v=0, d=0, state=RUN.
REQ-031 SHALL hold outputs during reset: alloc_gnt_o=0, alloc_rid_o=0, cmt_o=0, cmt_rid_o=0, count_o=0, full_o=0, empty_o=1.
REQ-032 SHALL abort any in-progress flush on reset mid-operation; no residual state survives.

Structure
REQ-033 SHALL take ROB_ENTRIES and Rid from the shared package; add to the package a ROB pointer typedef (wrap bit + 6-bit index) and the FSM state enum (RUN, FLUSH).
REQ-034 SHALL be a single module with no sub-modules; squash mask computed by comparing each entry's age relative to head.

Verification
REQ-035 SHALL test reset: after rst_i release, empty_o=1, count_o=0, alloc_rid_o=0, cmt_o=0.
REQ-036 SHALL test fill: 64 consecutive alloc_req_i -> rids 0..63 granted, full_o=1, 65th request alloc_gnt_o=0.
REQ-037 SHALL test wrap: alloc 64, done+commit rids 0..3, alloc 4 more -> rids 0..3 reissued, count_o=64, full_o=1.
REQ-038 SHALL test in-order commit: alloc 3, done rid 2 then rid 0 -> only rid 0 commits; rid 1 blocks until done; cmt_rdy_i=0 holds cmt_o=1, cmt_rid_o=1.
REQ-039 SHALL test flush: alloc rids 0..9, flush_rid_i=4 with simultaneous commit of rid 0 -> tail=5, count_o=4, alloc next cycle refused (FLUSH), following cycle grants rid 5.
REQ-040 SHALL test reset mid-flush: rst_i asserted during FLUSH -> all outputs at reset values on the same edge.

Source files
------------

// File: rtl/any1_rob_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : any1_rob_ctrl_pkg
//  Description : Shared types for the ANY1 reorder-buffer controller.
//                ROB depth, rid type, head/tail pointer layout
//                (wrap bit + index) and controller state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package any1_rob_ctrl_pkg;

    localparam int ROB_ENTRIES = 64;

    typedef logic [5:0] Rid;

    // A wrap bit beside the index lets full (same index, different wrap)
    // be told apart from empty (identical pointers).
    typedef struct packed {
        logic wrap;
        Rid   idx;
    } rob_ptr_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rob_state_t;

endpackage
`default_nettype wire

// File: rtl/any1_rob_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : any1_rob_ctrl
//  Description : Reorder-buffer bookkeeping. Allocates rids at the tail,
//                records completions, offers the head for in-order commit
//                and truncates the tail on a branch redirect.
//  Ports       : clk_i, rst_i (async, active high)
//                alloc_req_i / alloc_gnt_o / alloc_rid_o   allocation
//                done_i / done_rid_i                       completion
//                cmt_o / cmt_rid_o / cmt_rdy_i             commit handshake
//                flush_i / flush_rid_i                     redirect
//                count_o / full_o / empty_o                occupancy status
//  Revision    : 1.0  initial release
// ============================================================================
module any1_rob_ctrl #(
    parameter int ROB_ENTRIES = any1_rob_ctrl_pkg::ROB_ENTRIES
) (
    input  logic       rst_i,
    input  logic       clk_i,
    input  logic       alloc_req_i,
    output logic       alloc_gnt_o,
    output logic [5:0] alloc_rid_o,
    input  logic       done_i,
    input  logic [5:0] done_rid_i,
    output logic       cmt_o,
    output logic [5:0] cmt_rid_o,
    input  logic       cmt_rdy_i,
    input  logic       flush_i,
    input  logic [5:0] flush_rid_i,
    output logic [6:0] count_o,
    output logic       full_o,
    output logic       empty_o
);
    import any1_rob_ctrl_pkg::*;

    localparam logic [6:0] c_N   = 7'(ROB_ENTRIES);
    localparam logic [6:0] c_MOD = 7'(2 * ROB_ENTRIES - 1);

    // Pointers are converted to a linear position in [0, 2N) so that
    // arithmetic on them is plain addition modulo 2N.
    function automatic logic [6:0] to_lin(input rob_ptr_t p);
        to_lin = (p.wrap ? c_N : 7'd0) + {1'b0, p.idx};
    endfunction

    function automatic rob_ptr_t from_lin(input logic [6:0] l);
        logic [6:0] m;
        m             = l & c_MOD;
        from_lin.wrap = (m >= c_N);
        from_lin.idx  = (m >= c_N) ? 6'(m - c_N) : m[5:0];
    endfunction

    // Distance of an entry from the head, modulo N (0 = oldest).
    function automatic logic [6:0] age_of(input logic [5:0] idx, input logic [5:0] head);
        logic [6:0] a;
        a = {1'b0, idx} + c_N - {1'b0, head};
        if (a >= c_N) a = a - c_N;
        age_of = a;
    endfunction

    rob_ptr_t               r_head;
    rob_ptr_t               r_tail;
    logic [ROB_ENTRIES-1:0] r_v;
    logic [ROB_ENTRIES-1:0] r_d;
    rob_state_t             r_state;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_run;
    logic                   w_gnt;
    logic                   w_cmt;
    logic                   w_cmt_fire;
    logic                   w_flush_act;
    logic [6:0]             w_count;
    logic [6:0]             w_flush_age;
    rob_ptr_t               w_flush_tail;
    logic [ROB_ENTRIES-1:0] w_squash;
    logic [ROB_ENTRIES-1:0] w_v_next;
    logic [ROB_ENTRIES-1:0] w_d_next;

    assign w_count    = (to_lin(r_tail) - to_lin(r_head)) & c_MOD;
    assign w_full     = (r_tail.idx == r_head.idx) && (r_tail.wrap != r_head.wrap);
    assign w_empty    = (r_tail == r_head);
    assign w_run      = (r_state == RUN);
    // rst_i gates the grant so the combinational path is quiet during reset.
    assign w_gnt      = alloc_req_i & ~w_full & ~flush_i & w_run & ~rst_i;
    assign w_cmt      = r_v[r_head.idx] & r_d[r_head.idx] & w_run;
    assign w_cmt_fire = w_cmt & cmt_rdy_i;

    // A redirect to an unallocated rid squashes nothing and keeps the tail.
    assign w_flush_act  = flush_i & w_run & r_v[flush_rid_i];
    assign w_flush_age  = age_of(flush_rid_i, r_head.idx);
    assign w_flush_tail = from_lin(to_lin(r_head) + w_flush_age + 7'd1);

    // Everything strictly younger than the redirecting rid goes. The head
    // has age 0 and can never be squashed; entries past the tail are
    // already invalid, so no upper bound is needed.
    for (genvar gi = 0; gi < ROB_ENTRIES; gi++) begin : g_squash
        assign w_squash[gi] = w_flush_act && (age_of(6'(gi), r_head.idx) > w_flush_age);
    end

    always_comb begin
        w_v_next = r_v & ~w_squash;
        w_d_next = r_d;
        if (done_i && r_v[done_rid_i] && !w_squash[done_rid_i])
            w_d_next[done_rid_i] = 1'b1;
        if (w_gnt) begin
            w_v_next[r_tail.idx] = 1'b1;
            w_d_next[r_tail.idx] = 1'b0;
        end
        if (w_cmt_fire)
            w_v_next[r_head.idx] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_v     <= '0;
            r_d     <= '0;
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:     if (flush_i) r_state <= FLUSH;
                FLUSH:   r_state <= RUN;
                default: r_state <= RUN;
            endcase
            if (w_flush_act)
                r_tail <= w_flush_tail;
            else if (w_gnt)
                r_tail <= from_lin(to_lin(r_tail) + 7'd1);
            if (w_cmt_fire)
                r_head <= from_lin(to_lin(r_head) + 7'd1);
            r_v <= w_v_next;
            r_d <= w_d_next;
        end
    end

    assign alloc_gnt_o = w_gnt;
    assign alloc_rid_o = r_tail.idx;
    assign cmt_o       = w_cmt;
    assign cmt_rid_o   = r_head.idx;
    assign count_o     = w_count;
    assign full_o      = w_full;
    assign empty_o     = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_any1_rob_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_any1_rob_ctrl
//  Description : Self-checking bench for any1_rob_ctrl. Granted rids are
//                pushed to a scoreboard queue in allocation order and popped
//                when the head commits; occupancy is the queue depth.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_any1_rob_ctrl;

    logic       rst_i;
    logic       clk_i;
    logic       alloc_req_i;
    logic       alloc_gnt_o;
    logic [5:0] alloc_rid_o;
    logic       done_i;
    logic [5:0] done_rid_i;
    logic       cmt_o;
    logic [5:0] cmt_rid_o;
    logic       cmt_rdy_i;
    logic       flush_i;
    logic [5:0] flush_rid_i;
    logic [6:0] count_o;
    logic       full_o;
    logic       empty_o;

    int n_checks = 0;
    int n_errors = 0;
    int m_tail   = 0;
    int sb_q[$];

    any1_rob_ctrl dut (
        .rst_i      (rst_i),
        .clk_i      (clk_i),
        .alloc_req_i(alloc_req_i),
        .alloc_gnt_o(alloc_gnt_o),
        .alloc_rid_o(alloc_rid_o),
        .done_i     (done_i),
        .done_rid_i (done_rid_i),
        .cmt_o      (cmt_o),
        .cmt_rid_o  (cmt_rid_o),
        .cmt_rdy_i  (cmt_rdy_i),
        .flush_i    (flush_i),
        .flush_rid_i(flush_rid_i),
        .count_o    (count_o),
        .full_o     (full_o),
        .empty_o    (empty_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        alloc_req_i = 1'b1;
        #1;
        check("rst_gnt",   int'(alloc_gnt_o), 0);
        check("rst_rid",   int'(alloc_rid_o), 0);
        check("rst_cmt",   int'(cmt_o), 0);
        check("rst_crid",  int'(cmt_rid_o), 0);
        check("rst_count", int'(count_o), 0);
        check("rst_full",  int'(full_o), 0);
        check("rst_empty", int'(empty_o), 1);
        tick();
        rst_i       = 1'b0;
        alloc_req_i = 1'b0;
        sb_q.delete();
        m_tail = 0;
        #1;
    endtask

    task automatic do_alloc(input int exp_gnt);
        alloc_req_i = 1'b1;
        #1;
        check("alloc_gnt", int'(alloc_gnt_o), exp_gnt);
        if (exp_gnt != 0) begin
            check("alloc_rid", int'(alloc_rid_o), m_tail);
            sb_q.push_back(m_tail);
            m_tail = (m_tail + 1) % 64;
        end
        tick();
        alloc_req_i = 1'b0;
    endtask

    task automatic do_done(input int rid);
        done_i     = 1'b1;
        done_rid_i = 6'(rid);
        tick();
        done_i = 1'b0;
    endtask

    task automatic do_commit();
        int exp;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : -1;
        cmt_rdy_i = 1'b1;
        #1;
        check("cmt_valid", int'(cmt_o), 1);
        check("cmt_rid",   int'(cmt_rid_o), exp);
        tick();
        cmt_rdy_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        alloc_req_i = 1'b0;
        done_i      = 1'b0;
        done_rid_i  = '0;
        cmt_rdy_i   = 1'b0;
        flush_i     = 1'b0;
        flush_rid_i = '0;
        tick();

        // ---------------- reset ----------------
        do_reset();
        check("init_empty", int'(empty_o), 1);
        check("init_count", int'(count_o), 0);
        check("init_rid",   int'(alloc_rid_o), 0);
        check("init_cmt",   int'(cmt_o), 0);

        // ---------------- fill ----------------
        for (int i = 0; i < 64; i++) do_alloc(1);
        check("fill_full",  int'(full_o), 1);
        check("fill_count", int'(count_o), sb_q.size());
        do_alloc(0);

        // ---------------- wrap ----------------
        for (int i = 0; i < 4; i++) do_done(i);
        for (int i = 0; i < 4; i++) do_commit();
        check("wrap_count60", int'(count_o), sb_q.size());
        for (int i = 0; i < 4; i++) do_alloc(1);
        check("wrap_count", int'(count_o), 64);
        check("wrap_full",  int'(full_o), 1);
        // full with a commit in the same cycle still refuses allocation
        do_done(4);
        alloc_req_i = 1'b1;
        cmt_rdy_i   = 1'b1;
        #1;
        check("nobypass_gnt", int'(alloc_gnt_o), 0);
        check("nobypass_cmt", int'(cmt_o), 1);
        check("nobypass_rid", int'(cmt_rid_o), sb_q.pop_front());
        tick();
        alloc_req_i = 1'b0;
        cmt_rdy_i   = 1'b0;
        check("nobypass_count", int'(count_o), sb_q.size());
        do_reset();

        // ---------------- in-order commit ----------------
        for (int i = 0; i < 3; i++) do_alloc(1);
        do_done(2);
        check("ooo_no_cmt", int'(cmt_o), 0);
        done_i     = 1'b1;
        done_rid_i = 6'd0;
        #1;
        check("done_latency", int'(cmt_o), 0);
        tick();
        done_i = 1'b0;
        do_commit();
        #1;
        check("block_cmt", int'(cmt_o), 0);
        check("block_rid", int'(cmt_rid_o), 1);
        do_done(1);
        for (int i = 0; i < 2; i++) begin
            check("hold_cmt", int'(cmt_o), 1);
            check("hold_rid", int'(cmt_rid_o), 1);
            tick();
        end
        do_commit();
        do_commit();
        check("io_empty", int'(empty_o), 1);
        // completion aimed at an unallocated entry must not stick
        do_done(3);
        do_alloc(1);
        check("done_invalid", int'(cmt_o), 0);
        do_reset();

        // ---------------- flush ----------------
        for (int i = 0; i < 10; i++) do_alloc(1);
        do_done(0);
        do_done(7);
        flush_i     = 1'b1;
        flush_rid_i = 6'd4;
        cmt_rdy_i   = 1'b1;
        alloc_req_i = 1'b1;
        #1;
        check("flush_gnt",     int'(alloc_gnt_o), 0);
        check("flush_cmt",     int'(cmt_o), 1);
        check("flush_cmt_rid", int'(cmt_rid_o), sb_q.pop_front());
        while (sb_q.size() > 0 && sb_q[$] != 4) void'(sb_q.pop_back());
        m_tail = 5;
        tick();
        // FLUSH state: allocation refused, a second redirect ignored
        flush_i     = 1'b1;
        flush_rid_i = 6'd1;
        cmt_rdy_i   = 1'b0;
        #1;
        check("fl_gnt",   int'(alloc_gnt_o), 0);
        check("fl_count", int'(count_o), sb_q.size());
        check("fl_tail",  int'(alloc_rid_o), 5);
        check("fl_cmt",   int'(cmt_o), 0);
        tick();
        flush_i     = 1'b0;
        alloc_req_i = 1'b0;
        do_alloc(1);
        // rid 7 was squashed and reallocated? no: rid 5 is new, must not be done
        for (int i = 1; i <= 4; i++) do_done(i);
        for (int i = 0; i < 4; i++) do_commit();
        #1;
        check("fl_new_not_done", int'(cmt_o), 0);
        do_done(5);
        do_commit();
        check("fl_empty", int'(empty_o), 1);

        // ---------------- reset mid-flush ----------------
        do_reset();
        do_alloc(1);
        do_alloc(1);
        flush_i     = 1'b1;
        flush_rid_i = 6'd0;
        tick();
        flush_i     = 1'b0;
        rst_i       = 1'b1;
        alloc_req_i = 1'b1;
        #1;
        check("mid_gnt",   int'(alloc_gnt_o), 0);
        check("mid_rid",   int'(alloc_rid_o), 0);
        check("mid_cmt",   int'(cmt_o), 0);
        check("mid_crid",  int'(cmt_rid_o), 0);
        check("mid_count", int'(count_o), 0);
        check("mid_full",  int'(full_o), 0);
        check("mid_empty", int'(empty_o), 1);
        tick();
        rst_i       = 1'b0;
        alloc_req_i = 1'b0;
        sb_q.delete();
        m_tail = 0;
        #1;
        do_alloc(1);
        check("mid_count1", int'(count_o), sb_q.size());

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
